// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard and stall sequencer (optional stall counter: HAZARD_PERF_CNT_EN)
module hazard_ctrl #(
  parameter int REG_W        = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  input  logic             halt_req,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH, HALT} state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] fcnt, fcnt_nxt;
  logic       lu;

  // Load in EX writes a register the instruction in ID reads; r0 never hazards.
  assign lu = ex_mem_read && (ex_rt != '0) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  // State and flush-counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      fcnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // Next-state and zero-latency pipeline control decode.
  always_comb begin
    state_nxt   = state;
    fcnt_nxt    = fcnt;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    halted      = 1'b0;
    if (rst) begin
      idex_bubble = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (halt_req) begin
            idex_bubble = 1'b1;
            state_nxt   = HALT;
          end else if (mem_busy) begin
            state_nxt = MEM_WAIT;
          end else if (ex_branch_taken) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_nxt = FLUSH;
              fcnt_nxt  = FLUSH_INIT;
            end
          end else if (lu) begin
            idex_bubble = 1'b1;
          end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!mem_busy) state_nxt = RUN;
        end
        FLUSH: begin
          if (!mem_busy) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            fcnt_nxt    = fcnt - 4'd1;
            if (fcnt == 4'd1) state_nxt = RUN;
          end
        end
        HALT: begin
          idex_bubble = 1'b1;
          halted      = 1'b1;
          if (!halt_req) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of cycles in which fetch was held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!pc_write && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard testbench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int FC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, ex_branch_taken, mem_busy, halt_req;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, halted;
  logic [15:0] stall_cnt;
  logic       pc_write2, ifid_write2, ifid_flush2, idex_bubble2, halted2;
  logic [1:0] stall_cnt2;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic        pc;
    logic        iw;
    logic        fl;
    logic        bb;
    logic        hl;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // reference model state: pending halt/wait, remaining squash cycles, stall total
  bit m_halt, m_wait;
  int m_left, m_cnt;

  hazard_ctrl #(.REG_W(5), .FLUSH_CYCLES(FC), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .halt_req(halt_req), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  hazard_ctrl #(.REG_W(5), .FLUSH_CYCLES(FC), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_busy(mem_busy), .halt_req(halt_req), .pc_write(pc_write2),
    .ifid_write(ifid_write2), .ifid_flush(ifid_flush2), .idex_bubble(idex_bubble2),
    .halted(halted2), .stall_cnt(stall_cnt2)
  );

  always #5 clk = ~clk;

  task automatic step(input bit r, input logic [4:0] rs, input logic [4:0] rt,
                      input bit uses, input bit mr, input logic [4:0] ert,
                      input bit br, input bit busy, input bit hr);
    exp_t e;
    bit   is_lu;
    @(posedge clk);
    #1;
    rst = r; id_rs = rs; id_rt = rt; id_uses_rt = uses; ex_mem_read = mr;
    ex_rt = ert; ex_branch_taken = br; mem_busy = busy; halt_req = hr;
    is_lu = mr && (ert != 0) && ((ert == rs) || (uses && (ert == rt)));
    e = '0;
    if (r) begin
      e.bb = 1'b1;
      m_halt = 0; m_wait = 0; m_left = 0; m_cnt = 0;
    end else begin
      e.cnt = 16'(m_cnt);
      if (m_halt) begin
        e.bb = 1; e.hl = 1;
        if (!hr) m_halt = 0;
      end else if (m_wait) begin
        if (!busy) m_wait = 0;
      end else if (m_left > 0) begin
        if (!busy) begin
          e.pc = 1; e.iw = 1; e.fl = 1; e.bb = 1;
          m_left--;
        end
      end else if (hr) begin
        e.bb = 1; m_halt = 1;
      end else if (busy) begin
        m_wait = 1;
      end else if (br) begin
        e.pc = 1; e.iw = 1; e.fl = 1; e.bb = 1;
        m_left = FC - 1;
      end else if (is_lu) begin
        e.bb = 1;
      end else begin
        e.pc = 1; e.iw = 1;
      end
      if (!e.pc && m_cnt < 65535) m_cnt++;
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation each cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [15:0] ec;
      logic [1:0]  ec2;
      mon_e = sb.pop_front();
`ifdef HAZARD_PERF_CNT_EN
      ec  = mon_e.cnt;
      ec2 = (mon_e.cnt > 3) ? 2'd3 : mon_e.cnt[1:0];
`else
      ec  = 16'd0;
      ec2 = 2'd0;
`endif
      checks++;
      if ({pc_write, ifid_write, ifid_flush, idex_bubble, halted} ===
          {mon_e.pc, mon_e.iw, mon_e.fl, mon_e.bb, mon_e.hl}) passes++;
      else $display("FAIL ctrl at %0t: got pc/iw/fl/bb/hl=%b%b%b%b%b want %b%b%b%b%b", $time,
                    pc_write, ifid_write, ifid_flush, idex_bubble, halted,
                    mon_e.pc, mon_e.iw, mon_e.fl, mon_e.bb, mon_e.hl);
      checks++;
      if ({pc_write2, ifid_write2, ifid_flush2, idex_bubble2, halted2} ===
          {mon_e.pc, mon_e.iw, mon_e.fl, mon_e.bb, mon_e.hl}) passes++;
      else $display("FAIL ctrl_sat at %0t: got %b%b%b%b%b want %b%b%b%b%b", $time,
                    pc_write2, ifid_write2, ifid_flush2, idex_bubble2, halted2,
                    mon_e.pc, mon_e.iw, mon_e.fl, mon_e.bb, mon_e.hl);
      checks++;
      if (stall_cnt === ec) passes++;
      else $display("FAIL stall_cnt at %0t: got %0d want %0d", $time, stall_cnt, ec);
      checks++;
      if (stall_cnt2 === ec2) passes++;
      else $display("FAIL stall_cnt_sat at %0t: got %0d want %0d", $time, stall_cnt2, ec2);
    end
  end

  initial begin
    rst = 1; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_mem_read = 0; ex_rt = 0;
    ex_branch_taken = 0; mem_busy = 0; halt_req = 0;
    m_halt = 0; m_wait = 0; m_left = 0; m_cnt = 0;

    // reset values
    step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    idle(1);
    // load-use on rs, one-cycle stall
    step(0, 5'd3, 5'd0, 0, 1, 5'd3, 0, 0, 0);
    idle(1);
    // load-use on rt
    step(0, 5'd1, 5'd4, 1, 1, 5'd4, 0, 0, 0);
    // r0 never hazards
    step(0, 5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 0);
    // branch overrides simultaneous load-use
    step(0, 5'd3, 5'd0, 0, 1, 5'd3, 1, 0, 0);
    idle(2);
    // mem_busy while in FLUSH with one squash cycle left
    step(0, 5'd1, 5'd2, 0, 0, 5'd0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0);
    idle(2);
    // halt held 4 cycles
    for (int i = 0; i < 4; i++) step(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 1);
    idle(2);
    // reset mid-MEM_WAIT
    step(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0);
    step(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0);
    step(1, 5'd1, 5'd2, 0, 0, 5'd0, 0, 1, 0);
    idle(2);
    // six back-to-back stalls saturate the 2-bit counter
    for (int i = 0; i < 6; i++) step(0, 5'd2, 5'd0, 0, 1, 5'd2, 0, 0, 0);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 19) == 0);
    end

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    checks++;
    if (sb.size() == 0) passes++;
    else $display("FAIL drain: got %0d pending want 0", sb.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall sequencer for the 5-stage core. It owns the fetch stage's `PC_write` enable and the IF/ID and ID/EX pipeline-register controls. It handles four events: load-use data hazards, taken-branch squashes, multi-cycle memory waits and halt requests. The fetch stage, the IF/ID register and the ID/EX register take their enables and flush/bubble strobes only from this block.

## Interface
- `REG_W`, 5: register-specifier width.
- `FLUSH_CYCLES`, 2: number of cycles squashed after a taken branch, 1..15.
- `CNT_W`, 16: stall-counter width.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_rs`  in  REG_W  source register 1 of the instruction in ID.
- `id_rt`  in  REG_W  source register 2 of the instruction in ID.
- `id_uses_rt`  in  1  instruction in ID reads `id_rt`.
- `ex_mem_read`  in  1  instruction in EX is a load.
- `ex_rt`  in  REG_W  destination register of the load in EX.
- `ex_branch_taken`  in  1  branch resolved taken in EX this cycle.
- `mem_busy`  in  1  data memory is not ready; the pipeline must freeze.
- `halt_req`  in  1  request to stop fetching and drain.
- `pc_write`  out  1  PC update enable; drives fetch `PC_write`.
- `ifid_write`  out  1  IF/ID register load enable.
- `ifid_flush`  out  1  IF/ID register clear to NOP.
- `idex_bubble`  out  1  ID/EX register load NOP instead of the decoded instruction.
- `halted`  out  1  block is in HALT.
- `stall_cnt`  out  CNT_W  count of cycles in which `pc_write`=0.

## Operation
- States: RUN, MEM_WAIT, FLUSH, HALT. A 4-bit flush counter `fcnt` is held alongside the state.
- The load-use condition `lu` is `ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt))`.
- Outputs are combinational from the current state and current inputs. The next state registers on `clk`.
- RUN evaluates conditions in priority order; the first true one applies:
  - `halt_req`: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1; next state is HALT.
  - `mem_busy`: `pc_write`=0, `ifid_write`=0, `idex_bubble`=0, `ifid_flush`=0; next state is MEM_WAIT.
  - `ex_branch_taken`: `pc_write`=1, `ifid_write`=1, `ifid_flush`=1, `idex_bubble`=1. If `FLUSH_CYCLES`>1, next state is FLUSH with `fcnt`=`FLUSH_CYCLES`-1; otherwise it stays RUN. The branch overrides a simultaneous `lu`.
  - `lu`: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1; stays RUN, so the hazard clears as the load advances.
  - none of the above: `pc_write`=1, `ifid_write`=1, `ifid_flush`=0, `idex_bubble`=0.
- MEM_WAIT:
  - Outputs are frozen (`pc_write`=`ifid_write`=`ifid_flush`=`idex_bubble`=0) for every cycle spent in MEM_WAIT, including the cycle in which `mem_busy` is seen low.
  - When `mem_busy`=0 is sampled, next state is RUN. This costs one restart cycle.
- FLUSH:
  - `mem_busy`=1 produces frozen outputs; `fcnt` is held and the state stays FLUSH.
  - Otherwise `pc_write`=1, `ifid_write`=1, `ifid_flush`=1, `idex_bubble`=1 and `fcnt` decrements. When `fcnt`==1, next state is RUN.
  - `halt_req` and `ex_branch_taken` are ignored in FLUSH.
- HALT:
  - `pc_write`=0, `ifid_write`=0, `idex_bubble`=1, `halted`=1.
  - When `halt_req`=0 is sampled, next state is RUN.
- `halted`=0 in all states other than HALT.

## Timing
- `rst` high asynchronously forces the state to RUN, `fcnt`=0 and `stall_cnt`=0.
- While `rst` is high the outputs are forced to `pc_write`=0, `ifid_write`=0, `ifid_flush`=0, `idex_bubble`=1, `halted`=0.
- The first edge after `rst` falls sees RUN decode.
- Reset asserted mid-FLUSH, MEM_WAIT or HALT aborts to RUN immediately, with no drain.
- Hazard response is zero-latency: outputs react in the same cycle the inputs arrive. State changes take effect one edge later.
- Load-use stall length is exactly 1 cycle per hazard instance.
- A taken branch squashes `FLUSH_CYCLES` consecutive non-frozen cycles: the branch cycle plus `FLUSH_CYCLES`-1 cycles in FLUSH.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cnt` increments by 1 on every clock edge at which `pc_write`=0 and `rst`=0.
  - It saturates at 2^CNT_W-1 and does not wrap.
- Not defined: `stall_cnt` is tied to 0 and no counter flops are built. The port list is unchanged.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_rt`=3, `id_rs`=3 for one cycle -> `pc_write`=0 and `idex_bubble`=1 that cycle, `pc_write`=1 the next; `stall_cnt`=1 with the macro.
- `ex_rt`=0 with `id_rs`=0 and `ex_mem_read`=1 -> no stall: `pc_write`=1, `idex_bubble`=0.
- Branch with `FLUSH_CYCLES`=2, `lu` true in the same cycle -> `ifid_flush`=1 for 2 cycles, `pc_write`=1 in both, back to RUN.
- `mem_busy` high for 3 cycles starting in FLUSH with `fcnt`=1 -> frozen for 3 cycles, then one flush cycle, then RUN.
- `halt_req` pulse held 4 cycles -> `halted`=1 for 4 cycles starting the cycle after assertion, `pc_write`=0 throughout, RUN afterwards.
- `rst` asserted mid-MEM_WAIT -> outputs at reset values without waiting for a clock edge; RUN decode after release. Separately, with `CNT_W`=2, force 5 stall cycles -> `stall_cnt`=3 (saturated).
